// File: rtl/cc_unit.sv
// Condition-code producer (two-stage LD_CC pipeline) and branch-evaluation
// responder with a req/ack handshake that stalls until pending CC updates retire.
module cc_unit #(
   parameter int unsigned DATA_W = 16,
   localparam int unsigned CC_W  = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              LD_CC,
   input  logic [DATA_W-1:0] Bus,
   input  logic              Eval_Req,
   input  logic [CC_W-1:0]   IR_NZP,
   output logic [CC_W-1:0]   CC,
   output logic              CC_Valid,
   output logic              Eval_Ack,
   output logic              BEN,
   output logic              Busy
);

   localparam logic [CC_W-1:0] CC_N = CC_W'(3'b100);
   localparam logic [CC_W-1:0] CC_Z = CC_W'(3'b010);
   localparam logic [CC_W-1:0] CC_P = CC_W'(3'b001);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   logic [DATA_W-1:0] r_data;
   logic              r_pend;
   logic              r_cc_valid;
   logic [CC_W-1:0]   r_cc;
   logic [CC_W-1:0]   r_nzp;
   logic              r_ben;
   logic              r_ack;
   logic              r_busy;
   state_t            r_state;

   logic [CC_W-1:0]   w_cc_dec;
   logic [CC_W-1:0]   w_nzp_nxt;
   logic              w_ben_nxt;
   state_t            w_state_nxt;

   // Stage A: capture the bus; pend marks a value not yet decoded into CC
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_data     <= '0;
         r_pend     <= 1'b0;
         r_cc_valid <= 1'b1;
      end else begin
         if (LD_CC) begin
            r_data <= Bus;
         end
         r_pend     <= LD_CC;
         r_cc_valid <= ~LD_CC;
      end
   end

   always_comb begin
      w_cc_dec = CC_P;
      if (r_data[DATA_W-1]) begin
         w_cc_dec = CC_N;
      end else if (r_data == '0) begin
         w_cc_dec = CC_Z;
      end
   end

   // Stage B: retire the pending value into the condition codes
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_cc <= CC_Z;
      end else if (r_pend) begin
         r_cc <= w_cc_dec;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_nzp   <= '0;
         r_ben   <= 1'b0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_nzp   <= w_nzp_nxt;
         r_ben   <= w_ben_nxt;
         r_ack   <= (w_state_nxt == S_RESP);
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   // The response is only allowed once no update is pending or arriving,
   // so BEN always sees the CC of the latest LD_CC.
   always_comb begin
      w_state_nxt = r_state;
      w_nzp_nxt   = r_nzp;
      w_ben_nxt   = r_ben;
      case (r_state)
         S_IDLE: begin
            if (Eval_Req) begin
               w_nzp_nxt = IR_NZP;
               if (!r_pend && !LD_CC) begin
                  w_state_nxt = S_RESP;
                  w_ben_nxt   = |(IR_NZP & r_cc);
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!r_pend && !LD_CC) begin
               w_state_nxt = S_RESP;
               w_ben_nxt   = |(r_nzp & r_cc);
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign CC       = r_cc;
   assign CC_Valid = r_cc_valid;
   assign Eval_Ack = r_ack;
   assign BEN      = r_ben;
   assign Busy     = r_busy;

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: directed steps plus random traffic, every
// cycle compared against a history-based reference model.
module tb_cc_unit;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned MAXC   = 4096;

   logic              Clk;
   logic              Reset;
   logic              LD_CC;
   logic [DATA_W-1:0] Bus;
   logic              Eval_Req;
   logic [2:0]        IR_NZP;
   logic [2:0]        CC;
   logic              CC_Valid;
   logic              Eval_Ack;
   logic              BEN;
   logic              Busy;

   cc_unit #(.DATA_W(DATA_W)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .LD_CC    (LD_CC),
      .Bus      (Bus),
      .Eval_Req (Eval_Req),
      .IR_NZP   (IR_NZP),
      .CC       (CC),
      .CC_Valid (CC_Valid),
      .Eval_Ack (Eval_Ack),
      .BEN      (BEN),
      .Busy     (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;

   // Input history per cycle
   logic              ld_h  [MAXC];
   logic              rst_h [MAXC];
   logic [DATA_W-1:0] bus_h [MAXC];

   // Transaction-level view of the evaluation handshake
   logic              m_active;
   int                m_ack_cyc;
   logic [2:0]        m_mask;
   logic              m_ben;

   logic [2:0] obs_cc;
   logic       obs_ccv, obs_ack, obs_ben, obs_busy;

   function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
      if (v == '0)             return 3'b010;
      else if ($signed(v) < 0) return 3'b100;
      else                     return 3'b001;
   endfunction

   // CC in cycle c comes from the latest LD_CC at or before c-2 since the last reset
   function automatic logic [2:0] cc_exp(input int c);
      for (int k = c - 1; k >= 0; k--) begin
         if (rst_h[k]) return 3'b010;
         if (k <= c - 2 && ld_h[k]) return cc_of(bus_h[k]);
      end
      return 3'b010;
   endfunction

   function automatic logic eff_ld(input int c);
      if (c < 0) return 1'b0;
      return ld_h[c] && !rst_h[c];
   endfunction

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic ld, input logic [DATA_W-1:0] bus,
                       input logic req, input logic [2:0] nzp);
      logic idle_c;
      Reset    = rst;
      LD_CC    = ld;
      Bus      = bus;
      Eval_Req = req;
      IR_NZP   = nzp;
      @(negedge Clk);
      obs_cc   = CC;
      obs_ccv  = CC_Valid;
      obs_ack  = Eval_Ack;
      obs_ben  = BEN;
      obs_busy = Busy;
      chk("CC",       obs_cc,         cc_exp(cyc));
      chk("CC_Valid", 3'(obs_ccv),    3'(!eff_ld(cyc - 1)));
      chk("Eval_Ack", 3'(obs_ack),    3'(m_active && m_ack_cyc == cyc));
      chk("BEN",      3'(obs_ben),    3'(m_ben));
      chk("Busy",     3'(obs_busy),   3'(m_active));
      ld_h[cyc]  = ld;
      rst_h[cyc] = rst;
      bus_h[cyc] = bus;
      if (rst) begin
         m_active  = 1'b0;
         m_ack_cyc = -1;
         m_ben     = 1'b0;
      end else begin
         idle_c = !m_active;
         if (m_active && m_ack_cyc == cyc) begin
            m_active  = 1'b0;
            m_ack_cyc = -1;
         end else if (idle_c && req) begin
            m_active  = 1'b1;
            m_ack_cyc = -1;
            m_mask    = nzp;
         end
         // Respond once neither this cycle nor the previous one carried an update
         if (m_active && m_ack_cyc == -1 && !ld && !eff_ld(cyc - 1)) begin
            m_ack_cyc = cyc + 1;
            m_ben     = |(m_mask & cc_exp(cyc));
         end
      end
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 3'b000);
   endtask

   initial begin
      logic [DATA_W-1:0] vals [3];
      logic [DATA_W-1:0] rb;
      logic [2:0]        rn;
      logic              rl, rq, rr;
      vals[0] = 16'h8000;
      vals[1] = 16'h0000;
      vals[2] = 16'h7FFF;

      Reset = 1'b1; LD_CC = 1'b0; Bus = '0; Eval_Req = 1'b0; IR_NZP = '0;
      m_active = 1'b0; m_ack_cyc = -1; m_mask = '0; m_ben = 1'b0;
      @(posedge Clk);
      #1;
      ld_h[0] = 1'b0; rst_h[0] = 1'b1; bus_h[0] = '0;
      cyc = 1;

      // Reset state, then immediate evaluation with mask Z
      step(1'b0, 1'b0, '0, 1'b1, 3'b010);
      chk("rst_cc", obs_cc, 3'b010);
      chk("rst_busy", 3'(obs_busy), 3'b000);
      step(1'b0, 1'b0, '0, 1'b0, 3'b000);
      chk("imm_ack", 3'(obs_ack), 3'b001);
      chk("imm_ben", 3'(obs_ben), 3'b001);
      idle(1);

      // CC update latency for N, Z, P
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, vals[i], 1'b0, 3'b000);
         step(1'b0, 1'b0, '0, 1'b0, 3'b000);
         chk("lat_ccv_lo", 3'(obs_ccv), 3'b000);
         step(1'b0, 1'b0, '0, 1'b0, 3'b000);
         chk("lat_ccv_hi", 3'(obs_ccv), 3'b001);
         chk("lat_cc", obs_cc, cc_of(vals[i]));
      end

      // Restore Z, then LD_CC coincident with Eval_Req
      step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000);
      idle(2);
      step(1'b0, 1'b1, 16'hFFFF, 1'b1, 3'b100);
      idle(2);
      chk("coinc_busy", 3'(obs_busy), 3'b001);
      step(1'b0, 1'b0, '0, 1'b0, 3'b000);
      chk("coinc_ack", 3'(obs_ack), 3'b001);
      chk("coinc_ben", 3'(obs_ben), 3'b001);
      idle(1);

      // Three back-to-back updates hold the request in WAIT
      step(1'b0, 1'b1, 16'h0001, 1'b1, 3'b001);
      step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000);
      step(1'b0, 1'b1, 16'h8001, 1'b0, 3'b000);
      idle(2);
      step(1'b0, 1'b0, '0, 1'b0, 3'b000);
      chk("b2b_ack", 3'(obs_ack), 3'b001);
      chk("b2b_ben", 3'(obs_ben), 3'b000);
      idle(1);

      // Masks 000/111 against each CC; IR_NZP changed after acceptance
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, vals[i], 1'b0, 3'b000);
         idle(2);
         step(1'b0, 1'b0, '0, 1'b1, 3'b000);
         step(1'b0, 1'b0, '0, 1'b0, 3'b111);
         chk("mask0_ben", 3'(obs_ben), 3'b000);
         step(1'b0, 1'b1, vals[i], 1'b1, 3'b111);
         step(1'b0, 1'b0, '0, 1'b0, 3'b000);
         idle(1);
         step(1'b0, 1'b0, '0, 1'b0, 3'b000);
         chk("mask7_ben", 3'(obs_ben), 3'b001);
      end

      // Held request is re-accepted right after RESP
      step(1'b0, 1'b0, '0, 1'b1, 3'b111);
      step(1'b0, 1'b0, '0, 1'b1, 3'b111);
      step(1'b0, 1'b0, '0, 1'b1, 3'b000);
      step(1'b0, 1'b0, '0, 1'b0, 3'b000);
      chk("reacc_ben", 3'(obs_ben), 3'b000);
      idle(1);

      // Reset during WAIT discards the request
      step(1'b0, 1'b1, 16'h1234, 1'b1, 3'b111);
      step(1'b1, 1'b0, '0, 1'b0, 3'b000);
      step(1'b0, 1'b0, '0, 1'b0, 3'b000);
      chk("rstw_cc", obs_cc, 3'b010);
      chk("rstw_ben", 3'(obs_ben), 3'b000);
      chk("rstw_busy", 3'(obs_busy), 3'b000);
      chk("rstw_ack", 3'(obs_ack), 3'b000);
      idle(3);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         rl = 1'($urandom_range(0, 9) < 3);
         rq = 1'($urandom_range(0, 9) < 4);
         rr = 1'($urandom_range(0, 199) == 0);
         rn = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       rb = 16'h0000;
            1:       rb = 16'h8000;
            default: rb = 16'($urandom);
         endcase
         step(rr, rl, rb, rq, rn);
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cc_unit.md
# cc_unit

Condition-code producer and branch-evaluation responder for the LC-3 datapath. It captures the value on the internal bus when the control FSM asserts LD_CC and derives the N/Z/P condition codes from it through a two-stage pipeline. It also serves branch-evaluation requests from the control FSM with a req/ack handshake. The unit stalls each request until every pending CC update has retired, so the returned BEN always reflects the most recent LD_CC.

## Interface
- DATA_W, 16, bus width; bit DATA_W-1 is the sign bit.

- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- LD_CC  in  1  capture Bus for a condition-code update this cycle.
- Bus  in  DATA_W  datapath bus value, sampled only when LD_CC=1.
- Eval_Req  in  1  branch-evaluation request; sampled only in IDLE.
- IR_NZP  in  3  branch mask {n,z,p}; latched when a request is accepted.
- CC  out  3  current condition codes {N,Z,P}; exactly one bit set.
- CC_Valid  out  1  1 when no CC update is pending.
- Eval_Ack  out  1  one-cycle pulse; BEN is valid in this cycle.
- BEN  out  1  branch enable, registered; holds until the next Eval_Ack.
- Busy  out  1  1 whenever the evaluation FSM is not in IDLE.

## Operation
- Stage A: if LD_CC=1, data_q <= Bus and pend <= 1. Otherwise pend <= 0 once stage B has consumed data_q.
- Stage B: if pend=1, CC <= decode(data_q).
- decode: N if data_q[DATA_W-1]=1. Z if data_q is all zeros. P otherwise. The output is one-hot.
- Back-to-back LD_CC: each value passes through both stages in order. pend stays 1 until one cycle after the last LD_CC.
- CC_Valid = ~pend.
- Evaluation FSM states:
  - IDLE, reset state: on Eval_Req=1, latch nzp_q <= IR_NZP.
    - If pend=0 and LD_CC=0, go to RESP.
    - Otherwise go to WAIT.
  - WAIT: stay while pend=1 or LD_CC=1. Otherwise go to RESP.
  - RESP: Eval_Ack=1, then return to IDLE unconditionally.
- BEN register: on every transition into RESP, BEN <= |(nzp_q & CC), using CC as it stands in the cycle of the transition.
- Eval_Req outside IDLE is ignored. IR_NZP changes after acceptance have no effect.
- Eval_Req=1 held through RESP is re-accepted in the following IDLE cycle as a new request.
- An LD_CC in the same cycle as an accepted Eval_Req is ordered before the evaluation, so BEN uses the new CC.
- A continuous LD_CC stream holds the FSM in WAIT indefinitely. This is permitted; the control FSM never does it.
- Mask 3'b000 produces BEN=0. Mask 3'b111 produces BEN=1.

## Timing
- Reset values:
  - CC = 3'b010 (Z), CC_Valid = 1, pend = 0, data_q = 0.
  - BEN = 0, Eval_Ack = 0, Busy = 0, state = IDLE.
- Reset asserted mid-operation: everything returns to its reset value on the next edge. Any pending update and any outstanding request are discarded, and no Eval_Ack is issued.
- CC update latency: LD_CC in cycle t gives the new CC visible in cycle t+2. CC_Valid is 0 in cycle t+1 and 1 in cycle t+2, provided there is no further LD_CC.
- Evaluation, no update pending: Eval_Req in cycle t gives Eval_Ack and BEN in cycle t+1.
- Eval_Req and LD_CC both in cycle t: WAIT during t+1, transition to RESP at the end of t+2, Eval_Ack in t+3.
- Eval_Req in cycle t with pend=1 from an LD_CC in t-1 (no LD_CC in t): Eval_Ack in t+2.
- Eval_Ack is high for exactly one cycle per accepted request. Minimum spacing between acks is 2 cycles.
- Busy is high in every WAIT and RESP cycle.

## Test plan
- Reset, then Eval_Req with IR_NZP=3'b010 in cycle 1 → Eval_Ack=1 and BEN=1 in cycle 2, with CC=3'b010 throughout.
- LD_CC with Bus=16'h8000 in cycle t → CC_Valid=0 in t+1; CC=3'b100 and CC_Valid=1 in t+2. Repeat with Bus=16'h0000 → 3'b010, and with Bus=16'h7FFF → 3'b001.
- LD_CC with Bus=16'hFFFF in the same cycle as Eval_Req with IR_NZP=3'b100 (previous CC = Z) → Busy in t+1 and t+2; Eval_Ack=1 and BEN=1 in t+3.
- LD_CC for three consecutive cycles (0x0001, 0x0000, 0x8001), with Eval_Req and IR_NZP=3'b001 in the first cycle → FSM stays in WAIT, CC passes through 001, 010, 100, and the final ack gives BEN=0.
- Masks 3'b000 and 3'b111 against each of the three CC values → BEN=0 and BEN=1 respectively. Changing IR_NZP after acceptance does not alter BEN.
- Assert Reset in the WAIT cycle after LD_CC+Eval_Req → no Eval_Ack, and CC=3'b010, BEN=0, Busy=0 on the next cycle.
